// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/mem/writeback with bus timeouts,
// illegal-control trap and retired-instruction counter. Strobes are Moore-decoded from state.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             ctl_branch,
  input  logic             ctl_memread,
  input  logic             ctl_memwrite,
  input  logic             ctl_memtoreg,
  input  logic             ctl_regwrite,
  input  logic [1:0]       ctl_fetchpc,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             wb_sel_mem,
  output logic             reg_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd7
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_FETCH   = 2'b01;
  localparam logic [1:0] ERR_DMEM    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  // Wait counter only has to reach MEM_TIMEOUT-1; the last value is the final allowed cycle.
  localparam bit              TO_EN       = (MEM_TIMEOUT > 0);
  localparam int              WAIT_W      = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int              WAIT_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LAST_I);

  state_e             state_q, state_d;
  logic [1:0]         err_q, err_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_hit;
  logic               illegal_ctl;
  logic               mem_op;

  assign timeout_hit = TO_EN && (wait_q == WAIT_LAST);
  assign illegal_ctl = ctl_memread & ctl_memwrite;
  assign mem_op      = ctl_memread | ctl_memwrite;

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    instret_d = instret_q;
    wait_d    = '0;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = ERR_FETCH;
        end else if (TO_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (illegal_ctl) begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end else if (mem_op) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = ERR_DMEM;
        end else if (TO_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        instret_d = instret_q + 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      err_q     <= ERR_NONE;
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
    end
  end

  // Strobes are forced low for the whole reset cycle, even mid-access.
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    wb_sel_mem = 1'b0;
    reg_we     = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'b00;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ready;
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = ctl_memwrite;
        end
        S_WB: begin
          reg_we     = ctl_regwrite;
          wb_sel_mem = ctl_memtoreg;
          pc_we      = 1'b1;
          pc_sel     = (ctl_branch & ~branch_taken) ? 2'b00 : ctl_fetchpc;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign err     = err_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: instruction-level reference model schedules inputs per phase
// and queues the expected per-cycle outputs; a negedge monitor pops and compares.
module tb_multicycle_sequencer;
  localparam int TO    = 15;
  localparam int CNT_W = 4;

  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;
  logic ctl_branch = 1'b0, ctl_memread = 1'b0, ctl_memwrite = 1'b0, ctl_memtoreg = 1'b0, ctl_regwrite = 1'b0;
  logic [1:0] ctl_fetchpc = 2'b00;
  logic branch_taken = 1'b0;
  logic imem_req, ir_load, dmem_req, dmem_we, wb_sel_mem, reg_we, pc_we;
  logic [1:0] pc_sel, err;
  logic [2:0] state;
  logic [CNT_W-1:0] instret;

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ctl_branch(ctl_branch), .ctl_memread(ctl_memread), .ctl_memwrite(ctl_memwrite),
    .ctl_memtoreg(ctl_memtoreg), .ctl_regwrite(ctl_regwrite), .ctl_fetchpc(ctl_fetchpc),
    .branch_taken(branch_taken), .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .wb_sel_mem(wb_sel_mem), .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .state(state), .err(err), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic br, mr, mw, m2r, rw;
    logic [1:0] fpc;
    logic bt;
  } ins_t;

  typedef struct packed {
    logic [2:0] state;
    logic imem_req, ir_load, dmem_req, dmem_we, wb_sel_mem, reg_we, pc_we;
    logic [1:0] pc_sel;
    logic [1:0] err;
    logic [CNT_W-1:0] instret;
  } obs_t;

  obs_t expq[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int m_instret = 0;
  logic [1:0] m_err = 2'b00;
  bit halted;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ins_t mk(logic br, logic mr, logic mw, logic m2r, logic rw, logic [1:0] fpc, logic bt);
    ins_t c;
    c.br = br; c.mr = mr; c.mw = mw; c.m2r = m2r; c.rw = rw; c.fpc = fpc; c.bt = bt;
    return c;
  endfunction

  // One clock cycle: drive inputs just after the edge and queue what the outputs must be.
  task automatic tick(input logic [2:0] st, input logic rst, input logic imr, input logic dmr,
                      input logic rnd_ctl, input ins_t c);
    obs_t e;
    ins_t d;
    logic [7:0] r;
    @(posedge clk);
    #1;
    r = 8'($urandom());
    d = rnd_ctl ? r : c;
    reset = rst; imem_ready = imr; dmem_ready = dmr;
    ctl_branch = d.br; ctl_memread = d.mr; ctl_memwrite = d.mw; ctl_memtoreg = d.m2r;
    ctl_regwrite = d.rw; ctl_fetchpc = d.fpc; branch_taken = d.bt;
    e = '0;
    e.state = st;
    e.err = m_err;
    e.instret = CNT_W'(m_instret);
    if (!rst) begin
      if (st == FETCH) begin
        e.imem_req = 1'b1;
        e.ir_load = imr;
      end else if (st == MEM) begin
        e.dmem_req = 1'b1;
        e.dmem_we = c.mw;
      end else if (st == WB) begin
        e.reg_we = c.rw;
        e.wb_sel_mem = c.m2r;
        e.pc_we = 1'b1;
        e.pc_sel = (c.br && !c.bt) ? 2'b00 : c.fpc;
      end
    end
    expq.push_back(e);
  endtask

  task automatic do_reset(input logic [2:0] st);
    tick(st, 1'b1, rb(), rb(), 1'b1, '0);
    m_err = 2'b00;
    m_instret = 0;
  endtask

  // iw/dw: ready-low cycles before ready (>= TO means never); rst_mem: reset after that many MEM waits.
  task automatic run_instr(input int iw, input int dw, input ins_t c, input int rst_mem, output bit hlt);
    hlt = 1'b0;
    for (int k = 0; k < iw && k < TO; k++) tick(FETCH, 1'b0, 1'b0, rb(), 1'b1, c);
    if (iw >= TO) begin
      m_err = 2'b01;
      hlt = 1'b1;
      return;
    end
    tick(FETCH, 1'b0, 1'b1, rb(), 1'b1, c);
    tick(DECODE, 1'b0, rb(), rb(), 1'b0, c);
    tick(EXECUTE, 1'b0, rb(), rb(), 1'b0, c);
    if (c.mr && c.mw) begin
      m_err = 2'b11;
      hlt = 1'b1;
      return;
    end
    if (c.mr || c.mw) begin
      for (int k = 0; k < dw && k < TO; k++) begin
        if (k == rst_mem) begin
          do_reset(MEM);
          return;
        end
        tick(MEM, 1'b0, rb(), 1'b0, 1'b0, c);
      end
      if (dw >= TO) begin
        m_err = 2'b10;
        hlt = 1'b1;
        return;
      end
      tick(MEM, 1'b0, rb(), 1'b1, 1'b0, c);
    end
    tick(WB, 1'b0, rb(), rb(), 1'b0, c);
    m_instret = (m_instret + 1) % (1 << CNT_W);
  endtask

  task automatic exec(input int iw, input int dw, input ins_t c, input int rst_mem);
    bit h;
    run_instr(iw, dw, c, rst_mem, h);
    if (h) begin
      for (int k = 0; k < 3; k++) tick(HALT, 1'b0, rb(), rb(), 1'b1, c);
      do_reset(HALT);
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 24);
    if (r == 0) return TO;
    if (r == 1) return TO - 1;
    return $urandom_range(0, 3);
  endfunction

  initial begin : monitor
    obs_t e, got;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        got = {state, imem_req, ir_load, dmem_req, dmem_we, wb_sel_mem, reg_we, pc_we, pc_sel, err, instret};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL outputs@cycle%0d: got st=%0d imreq=%b irl=%b dreq=%b dwe=%b wbm=%b rwe=%b pcwe=%b pcsel=%0d err=%0d ir=%0d ; required st=%0d imreq=%b irl=%b dreq=%b dwe=%b wbm=%b rwe=%b pcwe=%b pcsel=%0d err=%0d ir=%0d",
                   cyc, got.state, got.imem_req, got.ir_load, got.dmem_req, got.dmem_we, got.wb_sel_mem,
                   got.reg_we, got.pc_we, got.pc_sel, got.err, got.instret,
                   e.state, e.imem_req, e.ir_load, e.dmem_req, e.dmem_we, e.wb_sel_mem,
                   e.reg_we, e.pc_we, e.pc_sel, e.err, e.instret);
        end
      end
    end
  end

  initial begin : stimulus
    ins_t c;
    int dw;
    do_reset(FETCH);
    do_reset(FETCH);
    // Directed: R-type, load with 3 waits, store, branches, jal/jalr.
    exec(0, 0, mk(0, 0, 0, 0, 1, 2'b00, 0), -1);
    exec(0, 3, mk(0, 1, 0, 1, 1, 2'b00, 0), -1);
    exec(1, 0, mk(0, 0, 1, 0, 0, 2'b00, 0), -1);
    exec(0, 0, mk(1, 0, 0, 0, 0, 2'b01, 0), -1);
    exec(0, 0, mk(1, 0, 0, 0, 0, 2'b01, 1), -1);
    exec(0, 0, mk(0, 0, 0, 0, 1, 2'b10, 0), -1);
    exec(2, 0, mk(1, 0, 0, 0, 1, 2'b11, 1), -1);
    // Timeout boundary: ready on the last allowed cycle vs never.
    exec(TO - 1, 0, mk(0, 0, 0, 0, 1, 2'b00, 0), -1);
    exec(TO, 0, mk(0, 0, 0, 0, 1, 2'b00, 0), -1);
    exec(0, TO - 1, mk(0, 1, 0, 1, 1, 2'b00, 0), -1);
    exec(0, TO, mk(0, 0, 1, 0, 0, 2'b00, 0), -1);
    exec(0, 0, mk(0, 1, 1, 0, 1, 2'b00, 0), -1);
    exec(0, 5, mk(0, 1, 0, 1, 1, 2'b00, 0), 2);
    // Wrap of the 4-bit counter through 15 -> 0.
    for (int i = 0; i < 18; i++) exec(0, 0, mk(0, 0, 0, 0, 1, 2'b00, 0), -1);
    // Randomized instruction stream.
    for (int i = 0; i < 150; i++) begin
      c = 8'($urandom());
      if (c.mr && c.mw && $urandom_range(0, 9) != 0) c.mw = 1'b0;
      dw = pick_wait();
      exec(pick_wait(), dw, c, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
    end
    @(negedge clk);
    #2;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked entries, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences the single-datapath CPU: fetch, decode, execute, memory, writeback.
- Consumes the static decode outputs of main_controll (Branch, MemRead, MemWrite, MemtoReg, RegWrite, fetchPC) and turns them into per-state enables, memory handshakes and PC update strobes.
- Adds bus-timeout detection, illegal-control detection and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 15, max wait cycles for imem/dmem ready per access; 0 disables the timeout.
- CNT_W, 32, width of instret counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- ctl_branch  in  1  Branch from main_controll
- ctl_memread  in  1  MemRead from main_controll
- ctl_memwrite  in  1  MemWrite from main_controll
- ctl_memtoreg  in  1  MemtoReg from main_controll
- ctl_regwrite  in  1  RegWrite from main_controll
- ctl_fetchpc  in  2  fetchPC from main_controll: 00 PC+4, 01 branch target, 10 jal, 11 jalr
- branch_taken  in  1  ALU branch comparison result
- imem_req  out  1  instruction fetch request
- ir_load  out  1  load instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable, valid with dmem_req
- wb_sel_mem  out  1  writeback mux selects memory data
- reg_we  out  1  register file write strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  2  next-PC source
- state  out  3  current FSM state
- err  out  2  sticky error: 00 none, 01 fetch timeout, 10 dmem timeout, 11 illegal control
- instret  out  CNT_W  retired instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=7.
- Reset (synchronous) applies at the next clk edge from any state, including mid-access:
  - state=FETCH, err=0, instret=0, wait counter=0.
  - While reset is high, all other outputs are 0.
- FETCH:
  - imem_req=1.
  - If imem_ready is high on a clock edge: ir_load=1 in that same cycle (combinational), then go to DECODE.
- DECODE: 1 cycle, then EXECUTE. ctl_* inputs are valid from DECODE onward and held stable by the IR.
- EXECUTE: 1 cycle.
  - ctl_memread & ctl_memwrite both high: go to HALT, err=11.
  - Otherwise, either memread or memwrite high: go to MEM.
  - Otherwise: go to WB.
- MEM:
  - dmem_req=1, dmem_we=ctl_memwrite.
  - When dmem_ready is high: go to WB.
- WB (1 cycle):
  - reg_we=ctl_regwrite; wb_sel_mem=ctl_memtoreg; pc_we=1.
  - pc_sel = 00 if ctl_branch & !branch_taken, else ctl_fetchpc.
  - instret increments (wraps modulo 2^CNT_W); then go to FETCH.
- HALT: all strobes 0; stays until reset. err holds its value.
- Handshake rules:
  - imem_ready is ignored outside FETCH; dmem_ready is ignored outside MEM.
  - Requests stay high continuously until ready is sampled.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle ready is low.
  - If ready has not been seen after MEM_TIMEOUT cycles, go to HALT with err=01 (FETCH) or 10 (MEM).
  - Ready arriving in the last allowed cycle (counter == MEM_TIMEOUT-1) completes normally.
  - MEM_TIMEOUT=0: wait forever.
- Latency with zero-wait memories:
  - Non-memory instruction: 4 cycles (F, D, E, WB).
  - Load/store: 5 cycles.
  - Each memory wait cycle adds 1.
- ctl_* inputs are ignored in FETCH; outputs are Moore-decoded from state, except ir_load, which also uses imem_ready.

Test Plan:
- Reset then R-type (regwrite=1, fetchpc=00), ready always 1 -> state sequence 0,1,2,4,0; reg_we and pc_we high in WB only, pc_sel=00, instret=1 after 4 cycles.
- Load (memread=1, memtoreg=1), dmem_ready delayed 3 cycles -> dmem_req high for exactly 4 cycles with dmem_we=0; WB asserts wb_sel_mem=1, reg_we=1; total 8 cycles.
- Branch (branch=1, fetchpc=01): branch_taken=0 -> pc_sel=00; branch_taken=1 -> pc_sel=01; jal (fetchpc=10, branch=0) -> pc_sel=10.
- imem_ready held low, MEM_TIMEOUT=15 -> HALT after 15 cycles, err=01; ready pulsed on the 15th wait cycle instead -> normal DECODE, err=00.
- memread=memwrite=1 in EXECUTE -> HALT, err=11, no dmem_req ever; reset high in HALT -> next cycle state=0, err=00, instret=0.
- Reset asserted mid-MEM with dmem_req high -> next edge dmem_req=0, state=FETCH; 2^CNT_W retirements (CNT_W=4 build) -> instret wraps 15 to 0.
